// File: rtl/mem_port_pkg.sv
// Shared types and lane helpers for the 16-bit memory port initiator.
package mem_port_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned WMASK_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [WMASK_W-1:0] WMASK_NONE = 2'b00;
  localparam logic [WMASK_W-1:0] WMASK_LO   = 2'b01;
  localparam logic [WMASK_W-1:0] WMASK_HI   = 2'b10;
  localparam logic [WMASK_W-1:0] WMASK_WORD = 2'b11;

  // Byte-lane enables for a request; loads never enable a lane.
  function automatic logic [WMASK_W-1:0] lane_mask(input logic write,
                                                    input logic is_byte,
                                                    input logic addr0);
    logic [WMASK_W-1:0] m;
    if (!write)       m = WMASK_NONE;
    else if (!is_byte) m = WMASK_WORD;
    else if (addr0)   m = WMASK_HI;
    else              m = WMASK_LO;
    return m;
  endfunction

  // Byte stores replicate the byte on both lanes so the mask alone selects it.
  function automatic logic [DATA_W-1:0] store_data(input logic write,
                                                    input logic is_byte,
                                                    input logic [DATA_W-1:0] wdata);
    logic [DATA_W-1:0] d;
    if (!write)       d = '0;
    else if (is_byte) d = {wdata[7:0], wdata[7:0]};
    else              d = wdata;
    return d;
  endfunction

endpackage

// File: rtl/byte_lane_extract.sv
// Load-result formatter: selects the addressed byte lane and extends it.
module byte_lane_extract
  import mem_port_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic              addr0,
  input  logic              is_byte,
  input  logic              is_signed,
  output logic [DATA_W-1:0] result
);

  logic [7:0] lane;

  always_comb begin
    lane   = addr0 ? rdata[15:8] : rdata[7:0];
    result = rdata;
    if (is_byte) begin
      result = is_signed ? {{8{lane[7]}}, lane} : {8'h00, lane};
    end
  end

endmodule

// File: rtl/mem_port_master.sv
// Single-outstanding load/store initiator for the 16-bit magic-memory port,
// with lane steering, load extension, misalignment check and response timeout.
module mem_port_master
  import mem_port_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic               req_write,
  input  logic               req_byte,
  input  logic               req_signed,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  output logic               req_ready,
  output logic               done,
  output logic [DATA_W-1:0]  done_rdata,
  output logic               err,
  output logic               mem_read,
  output logic               mem_write,
  output logic [WMASK_W-1:0] mem_wmask,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_resp,
  input  logic [DATA_W-1:0]  mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t state_q, state_d;

  logic              wr_q, byte_q, sgn_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic               accept_c, timeout_c;
  logic [DATA_W-1:0]  ext_c;
  logic               sel_wr, sel_byte;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  logic               ready_d, done_d, err_d, read_d, write_d;
  logic [DATA_W-1:0]  rdata_d, wdata_d;
  logic [WMASK_W-1:0] wmask_d;
  logic [ADDR_W-1:0]  addr_d;

  byte_lane_extract u_extract (
    .rdata     (mem_rdata),
    .addr0     (addr_q[0]),
    .is_byte   (byte_q),
    .is_signed (sgn_q),
    .result    (ext_c)
  );

  assign timeout_c = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus the values every registered output takes after this edge.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    rdata_d  = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept_c = 1'b1;
          if (!req_byte && req_addr[0]) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
            cnt_d   = '0;
          end
        end
      end
      ACCESS: begin
        if (mem_resp) begin
          state_d = RESP;
          rdata_d = wr_q ? '0 : ext_c;
        end else if (timeout_c) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes for the first ACCESS cycle come from the request being accepted.
    sel_wr    = accept_c ? req_write : wr_q;
    sel_byte  = accept_c ? req_byte  : byte_q;
    sel_addr  = accept_c ? req_addr  : addr_q;
    sel_wdata = accept_c ? req_wdata : wdata_q;

    ready_d = (state_d == IDLE);
    done_d  = (state_d == RESP);
    read_d  = 1'b0;
    write_d = 1'b0;
    wmask_d = WMASK_NONE;
    addr_d  = '0;
    wdata_d = '0;
    if (state_d == ACCESS) begin
      read_d  = !sel_wr;
      write_d = sel_wr;
      wmask_d = lane_mask(sel_wr, sel_byte, sel_addr[0]);
      addr_d  = sel_addr;
      wdata_d = store_data(sel_wr, sel_byte, sel_wdata);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      byte_q  <= 1'b0;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept_c) begin
        wr_q    <= req_write;
        byte_q  <= req_byte;
        sgn_q   <= req_signed;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready   <= 1'b1;
      done        <= 1'b0;
      done_rdata  <= '0;
      err         <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_wmask   <= WMASK_NONE;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      req_ready   <= ready_d;
      done        <= done_d;
      done_rdata  <= rdata_d;
      err         <= err_d;
      mem_read    <= read_d;
      mem_write   <= write_d;
      mem_wmask   <= wmask_d;
      mem_address <= addr_d;
      mem_wdata   <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_master.sv
// Randomized self-checking bench for mem_port_master against a behavioural memory model.
module tb_mem_port_master;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write, req_byte, req_signed;
  logic [15:0] req_addr, req_wdata;
  logic        req_ready, done, err;
  logic [15:0] done_rdata;
  logic        mem_read, mem_write, mem_resp;
  logic [1:0]  mem_wmask;
  logic [15:0] mem_address, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_byte(req_byte),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .done(done), .done_rdata(done_rdata), .err(err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  // Responder: answers in strobe cycle resp_delay (1 = same cycle), never when 0.
  logic [15:0] rmem [256];
  int          scnt = 0;
  int          resp_delay = 1;
  logic        pre_clr, pre_en;
  logic [7:0]  pre_idx;
  logic [15:0] pre_val;

  always_comb begin
    mem_resp  = (mem_read || mem_write) && (resp_delay != 0) && (scnt + 1 == resp_delay);
    mem_rdata = rmem[mem_address[8:1]];
  end

  always @(posedge clk) begin
    if (pre_clr) begin
      for (int i = 0; i < 256; i++) rmem[i] <= 16'h0;
    end else if (pre_en) begin
      rmem[pre_idx] <= pre_val;
    end else if (mem_write && mem_resp) begin
      if (mem_wmask[0]) rmem[mem_address[8:1]][7:0]  <= mem_wdata[7:0];
      if (mem_wmask[1]) rmem[mem_address[8:1]][15:8] <= mem_wdata[15:8];
    end
    if ((mem_read || mem_write) && !mem_resp) scnt <= scnt + 1;
    else                                      scnt <= 0;
  end

  // Reference memory image, updated from architectural store semantics.
  logic [15:0] ref_mem [256];

  function automatic logic [15:0] model_load(input logic [15:0] word, input logic is_byte,
                                             input logic is_signed, input logic addr0);
    int v;
    if (!is_byte) return word;
    v = addr0 ? int'(word) / 256 : int'(word) % 256;
    if (is_signed && v >= 128) v = v + 65280;
    return 16'(v);
  endfunction

  task automatic preload(input logic [15:0] a, input logic [15:0] v);
    pre_idx = a[8:1];
    pre_val = v;
    pre_en  = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
    ref_mem[a[8:1]] = v;
  endtask

  // One transaction: drives a request, checks every bus cycle and the completion.
  task automatic do_req(input logic w, input logic b, input logic s, input logic [15:0] a,
                        input logic [15:0] wd, input int delay, input bit noise,
                        output logic [15:0] got);
    logic        mis, timed, exp_err;
    int          exp_strobes, strobes, done_cyc, k;
    logic [15:0] exp_rdata, exp_wdata;
    logic [1:0]  exp_wmask;
    mis         = !b && a[0];
    timed       = (delay == 0) || (delay > int'(TO));
    exp_err     = mis || timed;
    exp_strobes = mis ? 0 : (timed ? int'(TO) : delay);
    exp_rdata   = (exp_err || w) ? 16'h0 : model_load(ref_mem[a[8:1]], b, s, a[0]);
    exp_wmask   = !w ? 2'b00 : (!b ? 2'b11 : (a[0] ? 2'b10 : 2'b01));
    exp_wdata   = !w ? 16'h0 : (b ? {wd[7:0], wd[7:0]} : wd);
    got = 16'h0;
    resp_delay = delay;
    @(negedge clk);
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_wait: req_ready=%b want 1", req_ready);
    end
    req_write = w; req_byte = b; req_signed = s; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    if (noise) begin
      req_write = 1'b1; req_byte = 1'b0; req_addr = {a[15:1], 1'b0}; req_wdata = ~wd;
    end else begin
      req_valid = 1'b0;
    end
    strobes  = 0;
    done_cyc = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        strobes++;
        n_cmp++;
        if ({mem_read, mem_write, mem_wmask, mem_address, mem_wdata} !==
            {!w, w, exp_wmask, a, exp_wdata}) begin
          n_bad++;
          $display("FAIL strobe a=%h: rd=%b wr=%b mask=%b addr=%h wdata=%h want rd=%b wr=%b mask=%b addr=%h wdata=%h",
                   a, mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
                   !w, w, exp_wmask, a, exp_wdata);
        end
      end
      if (done) begin
        done_cyc = cyc;
        got = done_rdata;
        n_cmp++;
        if ({err, done_rdata} !== {exp_err, exp_rdata}) begin
          n_bad++;
          $display("FAIL result a=%h: err=%b rdata=%h want err=%b rdata=%h",
                   a, err, done_rdata, exp_err, exp_rdata);
        end
        break;
      end
    end
    n_cmp++;
    if (done_cyc != exp_strobes + 1 || strobes != exp_strobes) begin
      n_bad++;
      $display("FAIL timing a=%h: done_cyc=%0d strobes=%0d want done_cyc=%0d strobes=%0d",
               a, done_cyc, strobes, exp_strobes + 1, exp_strobes);
    end
    if (noise) begin
      @(posedge clk);
      #1 req_valid = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if ({done, req_ready, mem_read, mem_write} !== 4'b0100) begin
      n_bad++;
      $display("FAIL after_done a=%h: done=%b ready=%b rd=%b wr=%b want 0 1 0 0",
               a, done, req_ready, mem_read, mem_write);
    end
    if (w && !exp_err) begin
      if (exp_wmask[0]) ref_mem[a[8:1]][7:0]  = exp_wdata[7:0];
      if (exp_wmask[1]) ref_mem[a[8:1]][15:8] = exp_wdata[15:8];
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({req_ready, done, err, done_rdata, mem_read, mem_write, mem_wmask, mem_address, mem_wdata} !==
        {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0}) begin
      n_bad++;
      $display("FAIL reset_values: ready=%b done=%b err=%b rdata=%h rd=%b wr=%b mask=%b addr=%h wdata=%h",
               req_ready, done, err, done_rdata, mem_read, mem_write, mem_wmask, mem_address, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, done, mem_read, mem_write} !== 4'b1000) begin
      n_bad++;
      $display("FAIL idle_after_reset: ready=%b done=%b rd=%b wr=%b want 1 0 0 0",
               req_ready, done, mem_read, mem_write);
    end
  endtask

  task automatic test_word_load();
    logic [15:0] got;
    preload(16'h0040, 16'h1234);
    do_req(1'b0, 1'b0, 1'b0, 16'h0040, 16'h0, 1, 1'b0, got);
    n_cmp++;
    if (got !== 16'h1234) begin
      n_bad++;
      $display("FAIL word_load: got %h want 1234", got);
    end
  endtask

  task automatic test_byte_loads();
    logic [15:0] got;
    preload(16'h0010, 16'h80F1);
    do_req(1'b0, 1'b1, 1'b1, 16'h0011, 16'h0, 1, 1'b0, got);
    n_cmp++;
    if (got !== 16'hFF80) begin
      n_bad++;
      $display("FAIL byte_load_signed: got %h want ff80", got);
    end
    do_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, 1, 1'b0, got);
    n_cmp++;
    if (got !== 16'h00F1) begin
      n_bad++;
      $display("FAIL byte_load_unsigned: got %h want 00f1", got);
    end
  endtask

  task automatic test_stores();
    logic [15:0] got;
    do_req(1'b1, 1'b1, 1'b0, 16'h0021, 16'h12AB, 1, 1'b0, got);
    do_req(1'b0, 1'b1, 1'b0, 16'h0021, 16'h0, 1, 1'b0, got);
    n_cmp++;
    if (got !== 16'h00AB) begin
      n_bad++;
      $display("FAIL byte_store_readback: got %h want 00ab", got);
    end
    do_req(1'b1, 1'b0, 1'b0, 16'h0020, 16'hBEEF, 2, 1'b0, got);
    do_req(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0, 1, 1'b0, got);
    n_cmp++;
    if (got !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL word_store_readback: got %h want beef", got);
    end
  endtask

  task automatic test_misaligned();
    logic [15:0] got;
    do_req(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0, 1, 1'b0, got);
    do_req(1'b1, 1'b0, 1'b0, 16'h0021, 16'h5555, 1, 1'b0, got);
    do_req(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0, 1, 1'b0, got);
    n_cmp++;
    if (got !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL misaligned_no_write: got %h want beef", got);
    end
  endtask

  task automatic test_timeout();
    logic [15:0] got;
    do_req(1'b0, 1'b0, 1'b0, 16'h0040, 16'h0, 0, 1'b0, got);
    do_req(1'b0, 1'b0, 1'b0, 16'h0040, 16'h0, int'(TO), 1'b0, got);
    n_cmp++;
    if (got !== 16'h1234) begin
      n_bad++;
      $display("FAIL resp_last_cycle: got %h want 1234", got);
    end
    do_req(1'b1, 1'b0, 1'b0, 16'h0042, 16'h7777, int'(TO) + 1, 1'b0, got);
  endtask

  task automatic test_reset_abort();
    logic [15:0] got;
    resp_delay = 0;
    @(negedge clk);
    req_write = 1'b0; req_byte = 1'b0; req_addr = 16'h0040; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (mem_read !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_precond: mem_read=%b want 1", mem_read);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_read, mem_write, done, req_ready} !== 4'b0001) begin
      n_bad++;
      $display("FAIL async_abort: rd=%b wr=%b done=%b ready=%b want 0 0 0 1",
               mem_read, mem_write, done, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({done, mem_read, req_ready} !== 3'b001) begin
        n_bad++;
        $display("FAIL post_abort_idle: done=%b rd=%b ready=%b want 0 0 1", done, mem_read, req_ready);
      end
    end
    do_req(1'b0, 1'b0, 1'b0, 16'h0040, 16'h0, 1, 1'b0, got);
  endtask

  task automatic test_ignored_requests();
    logic [15:0] got;
    do_req(1'b0, 1'b1, 1'b0, 16'h0011, 16'hA5A5, 3, 1'b1, got);
    do_req(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0099, 1, 1'b1, got);
    do_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, 1, 1'b0, got);
    n_cmp++;
    if (got !== 16'h80F1) begin
      n_bad++;
      $display("FAIL ignored_store_0010: got %h want 80f1", got);
    end
    do_req(1'b0, 1'b0, 1'b0, 16'h0040, 16'h0, 2, 1'b0, got);
    n_cmp++;
    if (got !== 16'h1299) begin
      n_bad++;
      $display("FAIL ignored_store_0040: got %h want 1299", got);
    end
  endtask

  task automatic test_random();
    logic [15:0] got;
    for (int i = 0; i < 60; i++) begin
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             16'($urandom_range(0, 31)), 16'($urandom), int'($urandom_range(0, 5)),
             ($urandom_range(0, 3) == 0), got);
    end
    for (int a = 0; a < 32; a += 2) begin
      do_req(1'b0, 1'b0, 1'b0, 16'(a), 16'h0, 1, 1'b0, got);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
    req_addr = 16'h0; req_wdata = 16'h0;
    pre_en = 1'b0; pre_idx = 8'h0; pre_val = 16'h0; pre_clr = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;
    repeat (2) @(posedge clk);
    #1 pre_clr = 1'b0;
    test_reset();
    test_word_load();
    test_byte_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_reset_abort();
    test_ignored_requests();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
